// File: rtl/mux_bus_sel_sched_if.sv
// Bus bundle for mux_bus_sel_sched: channel data, enable mask, the select
// request handshake and the registered selection outputs.
interface mux_bus_sel_sched_if #(
  parameter int WIDTH    = 5,
  parameter int CHANNELS = 8,
  parameter int SEL_W    = $clog2(CHANNELS)
);
  logic [CHANNELS*WIDTH-1:0] din;
  logic [CHANNELS-1:0]       ch_en;
  logic                      mode;
  logic                      boundary;
  logic [SEL_W-1:0]          sel_in;
  logic                      sel_valid;
  logic                      sel_ready;
  logic                      sel_err;
  logic [SEL_W-1:0]          cur_sel;
  logic [WIDTH-1:0]          y;
  logic                      y_valid;

  // Request handshake: a request is taken on a rising edge where
  // sel_valid && sel_ready; sel_ready never depends on sel_valid.
  modport master (
    output din, ch_en, mode, boundary, sel_in, sel_valid,
    input  sel_ready, sel_err, cur_sel, y, y_valid
  );

  modport slave (
    input  din, ch_en, mode, boundary, sel_in, sel_valid,
    output sel_ready, sel_err, cur_sel, y, y_valid
  );
endinterface

// File: rtl/mux_bus_sel_sched.sv
// Registered N-channel bus selector; switches take effect only on a boundary strobe.
// Define MUX_SCAN_EN to build the round-robin auto-scan mode (mode input).
module mux_bus_sel_sched #(
  parameter int WIDTH    = 5,
  parameter int CHANNELS = 8,
  parameter int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                clk,
  input  logic                rst_n,
  mux_bus_sel_sched_if.slave  bus
);

  logic [SEL_W-1:0]     cur_sel_q, cur_sel_d;
  logic [SEL_W-1:0]     pend_sel_q, pend_sel_d;
  logic                 pending_q, pending_d;
  logic                 sel_err_q, sel_err_d;
  logic [WIDTH-1:0]     y_q, y_sel;
  logic                 y_valid_q;
  logic                 mode_eff;
  logic                 accept;
  logic [2**SEL_W-1:0]  ch_en_ext;

`ifdef MUX_SCAN_EN
  logic [SEL_W-1:0]     scan_next;
  assign mode_eff = bus.mode;
`else
  assign mode_eff = 1'b0;
`endif

  // Zero-padded mask so out-of-range indices read as disabled.
  always_comb begin
    ch_en_ext = '0;
    ch_en_ext[CHANNELS-1:0] = bus.ch_en;
  end

  assign bus.sel_ready = !pending_q && !mode_eff;
  assign accept        = bus.sel_valid && bus.sel_ready;

`ifdef MUX_SCAN_EN
  always_comb begin
    int   idx;
    logic found;
    scan_next = cur_sel_q;
    found     = 1'b0;
    for (int k = 1; k < CHANNELS; k++) begin
      idx = (int'(cur_sel_q) + k) % CHANNELS;
      if (!found && bus.ch_en[idx]) begin
        scan_next = SEL_W'(idx);
        found     = 1'b1;
      end
    end
  end
`endif

  always_comb begin
    cur_sel_d  = cur_sel_q;
    pend_sel_d = pend_sel_q;
    pending_d  = pending_q;
    sel_err_d  = 1'b0;
    if (mode_eff) begin
      // Entering scan drops any outstanding request silently.
      pending_d = 1'b0;
`ifdef MUX_SCAN_EN
      if (bus.boundary) cur_sel_d = scan_next;
`endif
    end else begin
      if (pending_q && bus.boundary) begin
        cur_sel_d = pend_sel_q;
        pending_d = 1'b0;
      end
      if (accept) begin
        if (ch_en_ext[bus.sel_in]) begin
          pend_sel_d = bus.sel_in;
          pending_d  = 1'b1;
        end else begin
          sel_err_d  = 1'b1;
        end
      end
    end
  end

  always_comb begin
    y_sel = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (cur_sel_d == SEL_W'(k)) y_sel = bus.din[k*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_sel_q  <= '0;
      pend_sel_q <= '0;
      pending_q  <= 1'b0;
      sel_err_q  <= 1'b0;
      y_q        <= '0;
      y_valid_q  <= 1'b0;
    end else begin
      cur_sel_q  <= cur_sel_d;
      pend_sel_q <= pend_sel_d;
      pending_q  <= pending_d;
      sel_err_q  <= sel_err_d;
      y_q        <= ch_en_ext[cur_sel_d] ? y_sel : '0;
      y_valid_q  <= ch_en_ext[cur_sel_d];
    end
  end

  assign bus.cur_sel = cur_sel_q;
  assign bus.y       = y_q;
  assign bus.y_valid = y_valid_q;
  assign bus.sel_err = sel_err_q;

endmodule
